// File: rtl/bus_seq_pkg.sv
// rtl/bus_seq_pkg.sv - shared codes and state type for the bus sequencer
// Purpose: bus source-select codes, opcodes, ALU operation codes and the
// sequencer state enum, imported by seq_decode and bus_sequencer.
package bus_seq_pkg;

    localparam logic [3:0] SEL_NONE = 4'd0;
    localparam logic [3:0] SEL_AR   = 4'd1;
    localparam logic [3:0] SEL_AC   = 4'd2;
    localparam logic [3:0] SEL_PC   = 4'd3;
    localparam logic [3:0] SEL_DR   = 4'd4;
    localparam logic [3:0] SEL_R    = 4'd5;
    localparam logic [3:0] SEL_IRAM = 4'd6;
    localparam logic [3:0] SEL_DRAM = 4'd7;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDAC  = 4'h1;
    localparam logic [3:0] OP_STAC  = 4'h2;
    localparam logic [3:0] OP_MVACR = 4'h3;
    localparam logic [3:0] OP_MVRAC = 4'h4;
    localparam logic [3:0] OP_ADD   = 4'h5;
    localparam logic [3:0] OP_SUB   = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_JMPZ  = 4'h8;
    localparam logic [3:0] OP_INCAC = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_INC  = 3'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_F1, S_F2, S_DEC, S_EXE, S_OPA, S_OPB,
        S_MRD, S_WB, S_MWR, S_HALT, S_ERR
    } state_t;

endpackage

// File: rtl/seq_decode.sv
// rtl/seq_decode.sv - combinational opcode classifier
// Purpose: sorts a 4-bit opcode into the instruction classes the sequencer
// branches on. NOP is the opcode that falls in no class.
// Ports: opcode (in, 4); is_reg, is_mem, is_jump, is_halt, illegal (out, 1 each).
module seq_decode
    import bus_seq_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_reg,
    output logic       is_mem,
    output logic       is_jump,
    output logic       is_halt,
    output logic       illegal
);

    always_comb begin
        is_reg  = 1'b0;
        is_mem  = 1'b0;
        is_jump = 1'b0;
        is_halt = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_NOP:                                        ;
            OP_LDAC, OP_STAC:                              is_mem  = 1'b1;
            OP_MVACR, OP_MVRAC, OP_ADD, OP_SUB, OP_INCAC:  is_reg  = 1'b1;
            OP_JMP, OP_JMPZ:                               is_jump = 1'b1;
            OP_HALT:                                       is_halt = 1'b1;
            default:                                       illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/bus_sequencer.sv
// rtl/bus_sequencer.sv - fetch/decode/execute sequencer for the 16-bit bus
// Purpose: Moore FSM driving bus_sel, register strobes, alu_op and the
// data-RAM request/write qualifiers, one instruction at a time.
// Ports: clk, rst_n (async, active low), start, ir[15:0], z_flag, dram_ready in;
// bus_sel[3:0], ld_ar, ld_pc, inc_pc, ld_ir, ld_dr, ld_r, ld_ac, alu_op[2:0],
// dram_req, dram_we, busy, halted, err out.
// Option macro SEQ_WAIT_TIMEOUT_EN: abort a data-RAM wait into ERR after
// TIMEOUT_CYCLES not-ready cycles.
module bus_sequencer
    import bus_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] ir,
    input  logic        z_flag,
    input  logic        dram_ready,
    output logic [3:0]  bus_sel,
    output logic        ld_ar,
    output logic        ld_pc,
    output logic        inc_pc,
    output logic        ld_ir,
    output logic        ld_dr,
    output logic        ld_r,
    output logic        ld_ac,
    output logic [2:0]  alu_op,
    output logic        dram_req,
    output logic        dram_we,
    output logic        busy,
    output logic        halted,
    output logic        err
);

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    state_t     state_q, state_d;
    // Opcode and zero flag are captured in DEC so EXE/OPB outputs come
    // from registers rather than from the ir/z_flag inputs.
    logic [3:0] op_q, op_d;
    logic       z_q, z_d;
    logic       is_reg, is_mem, is_jump, is_halt, illegal;
    logic       wait_expired;
    logic       unused_ir_operand;

    assign unused_ir_operand = ^ir[11:0];

    seq_decode u_decode (
        .opcode  (ir[15:12]),
        .is_reg  (is_reg),
        .is_mem  (is_mem),
        .is_jump (is_jump),
        .is_halt (is_halt),
        .illegal (illegal)
    );

`ifdef SEQ_WAIT_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] wait_cnt_q, wait_cnt_d;

    // Counter is zero whenever no not-ready wait is in progress, so it is
    // already clear on entry to MRD/MWR.
    always_comb begin
        wait_cnt_d   = 8'd0;
        wait_expired = 1'b0;
        if ((state_q == S_MRD || state_q == S_MWR) && !dram_ready) begin
            wait_cnt_d   = wait_cnt_q + 8'd1;
            wait_expired = (wait_cnt_d == TIMEOUT_LIMIT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign wait_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            z_q     <= z_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        z_d     = z_q;
        case (state_q)
            S_IDLE, S_HALT, S_ERR: if (start) state_d = S_F1;
            S_F1:  state_d = S_F2;
            S_F2:  state_d = S_DEC;
            S_DEC: begin
                op_d = ir[15:12];
                z_d  = z_flag;
                if (illegal)                state_d = S_ERR;
                else if (is_halt)           state_d = S_HALT;
                else if (is_reg)            state_d = S_EXE;
                else if (is_mem || is_jump) state_d = S_OPA;
                else                        state_d = S_F1;
            end
            S_EXE: state_d = S_F1;
            S_OPA: state_d = S_OPB;
            S_OPB: begin
                if (op_q == OP_LDAC)      state_d = S_MRD;
                else if (op_q == OP_STAC) state_d = S_MWR;
                else                      state_d = S_F1;
            end
            S_MRD: begin
                if (dram_ready)        state_d = S_WB;
                else if (wait_expired) state_d = S_ERR;
            end
            S_WB:  state_d = S_F1;
            S_MWR: begin
                if (dram_ready)        state_d = S_F1;
                else if (wait_expired) state_d = S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus_sel  = SEL_NONE;
        ld_ar    = 1'b0;
        ld_pc    = 1'b0;
        inc_pc   = 1'b0;
        ld_ir    = 1'b0;
        ld_dr    = 1'b0;
        ld_r     = 1'b0;
        ld_ac    = 1'b0;
        alu_op   = ALU_PASS;
        dram_req = 1'b0;
        dram_we  = 1'b0;
        busy     = 1'b1;
        halted   = 1'b0;
        err      = 1'b0;
        case (state_q)
            S_IDLE: busy = 1'b0;
            S_F1: begin bus_sel = SEL_PC;   ld_ar = 1'b1; end
            S_F2: begin bus_sel = SEL_IRAM; ld_ir = 1'b1; inc_pc = 1'b1; end
            S_DEC: ;
            S_EXE: begin
                case (op_q)
                    OP_MVACR: begin bus_sel = SEL_AC; ld_r = 1'b1; end
                    OP_MVRAC: begin bus_sel = SEL_R;  ld_ac = 1'b1; alu_op = ALU_PASS; end
                    OP_ADD:   begin bus_sel = SEL_R;  ld_ac = 1'b1; alu_op = ALU_ADD; end
                    OP_SUB:   begin bus_sel = SEL_R;  ld_ac = 1'b1; alu_op = ALU_SUB; end
                    OP_INCAC: begin bus_sel = SEL_AC; ld_ac = 1'b1; alu_op = ALU_INC; end
                    default: ;
                endcase
            end
            S_OPA: begin bus_sel = SEL_PC; ld_ar = 1'b1; end
            S_OPB: begin
                bus_sel = SEL_IRAM;
                if (op_q == OP_LDAC || op_q == OP_STAC) begin
                    ld_ar  = 1'b1;
                    inc_pc = 1'b1;
                end else if (op_q == OP_JMP || z_q) begin
                    ld_pc = 1'b1;
                end else begin
                    inc_pc = 1'b1;
                end
            end
            // ld_dr is the one strobe qualified by dram_ready: DR captures
            // the RAM word only on the edge that completes the access.
            S_MRD: begin bus_sel = SEL_DRAM; dram_req = 1'b1; ld_dr = dram_ready; end
            S_WB:  begin bus_sel = SEL_DR; ld_ac = 1'b1; alu_op = ALU_PASS; end
            S_MWR: begin bus_sel = SEL_AC; dram_req = 1'b1; dram_we = 1'b1; end
            S_HALT: begin busy = 1'b0; halted = 1'b1; end
            S_ERR:  begin busy = 1'b0; err = 1'b1; end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// tb/tb_bus_sequencer.sv - self-checking bench for bus_sequencer
module tb_bus_sequencer;

    localparam int TMO = 4;

    localparam logic [6:0] L_AR  = 7'b1000000;
    localparam logic [6:0] L_PC  = 7'b0100000;
    localparam logic [6:0] L_INC = 7'b0010000;
    localparam logic [6:0] L_IR  = 7'b0001000;
    localparam logic [6:0] L_DR  = 7'b0000100;
    localparam logic [6:0] L_R   = 7'b0000010;
    localparam logic [6:0] L_AC  = 7'b0000001;

    localparam logic [18:0] REST_IDLE = 19'd0;
    localparam logic [18:0] REST_HALT = 19'd2;
    localparam logic [18:0] REST_ERR  = 19'd1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] ir;
    logic        z_flag;
    logic        dram_ready = 1'b0;
    logic [3:0]  bus_sel;
    logic        ld_ar, ld_pc, inc_pc, ld_ir, ld_dr, ld_r, ld_ac;
    logic [2:0]  alu_op;
    logic        dram_req, dram_we, busy, halted, err;

    bus_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ir(ir), .z_flag(z_flag),
        .dram_ready(dram_ready), .bus_sel(bus_sel), .ld_ar(ld_ar), .ld_pc(ld_pc),
        .inc_pc(inc_pc), .ld_ir(ld_ir), .ld_dr(ld_dr), .ld_r(ld_r), .ld_ac(ld_ac),
        .alu_op(alu_op), .dram_req(dram_req), .dram_we(dram_we), .busy(busy),
        .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    logic [18:0] dut_vec;
    assign dut_vec = {bus_sel, ld_ar, ld_pc, inc_pc, ld_ir, ld_dr, ld_r, ld_ac,
                      alu_op, dram_req, dram_we, busy, halted, err};

    // Datapath the sequencer steers: registers, bus mux, ALU, IRAM, DRAM.
    logic [15:0] ar, pc, dr, r, ac, bus, alu_out;
    logic [15:0] iram [256];
    logic [15:0] dram [256];
    assign z_flag = (ac == 16'd0);

    always_comb begin
        case (bus_sel)
            4'd1: bus = ar;
            4'd2: bus = ac;
            4'd3: bus = pc;
            4'd4: bus = dr;
            4'd5: bus = r;
            4'd6: bus = iram[ar[7:0]];
            4'd7: bus = dram[ar[7:0]];
            default: bus = 16'd0;
        endcase
        case (alu_op)
            3'd1: alu_out = ac + bus;
            3'd2: alu_out = ac - bus;
            3'd3: alu_out = ac + 16'd1;
            default: alu_out = bus;
        endcase
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar <= 0; pc <= 0; ir <= 0; dr <= 0; r <= 0; ac <= 0;
        end else begin
            if (ld_ar) ar <= bus;
            if (ld_pc) pc <= bus;
            else if (inc_pc) pc <= pc + 16'd1;
            if (ld_ir) ir <= bus;
            if (ld_dr) dr <= bus;
            if (ld_r)  r <= bus;
            if (ld_ac) ac <= alu_out;
            if (dram_req && dram_we && dram_ready) dram[ar[7:0]] <= bus;
        end
    end

    // Data-RAM responder: ready after wait_n not-ready cycles of a request.
    int wait_n = 0;
    int rcnt = 0;
    always @(posedge clk) begin
        #1;
        if (dram_req) begin
            dram_ready = (rcnt >= wait_n);
            rcnt++;
        end else begin
            dram_ready = 1'b0;
            rcnt = 0;
        end
    end

    int n_checks = 0;
    int n_fail = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: expected output vector per cycle.
    logic [18:0] q[$];
    logic [18:0] m_rest = REST_IDLE;
    logic [15:0] m_pc = 0, m_ac = 0, m_r = 0;
    logic [15:0] m_dram [256];

    function automatic logic [18:0] mk(input logic [3:0] sel, input logic [6:0] ld,
                                       input logic [2:0] alu, input logic req, input logic we);
        return {sel, ld, alu, req, we, 3'b100};
    endfunction

    task automatic build(input int w);
        logic [15:0] ins, a;
        logic [3:0]  op;
        int          stall;
        bit          done, tmo;
        done = 0;
        q.push_back(m_rest);
        for (int n = 0; n < 32 && !done; n++) begin
            ins = iram[m_pc[7:0]];
            op  = ins[15:12];
            q.push_back(mk(4'd3, L_AR, 3'd0, 0, 0));
            q.push_back(mk(4'd6, L_IR | L_INC, 3'd0, 0, 0));
            q.push_back(mk(4'd0, 7'd0, 3'd0, 0, 0));
            m_pc = m_pc + 16'd1;
            case (op)
                4'h0: ;
                4'h3: begin q.push_back(mk(4'd2, L_R, 3'd0, 0, 0)); m_r = m_ac; end
                4'h4: begin q.push_back(mk(4'd5, L_AC, 3'd0, 0, 0)); m_ac = m_r; end
                4'h5: begin q.push_back(mk(4'd5, L_AC, 3'd1, 0, 0)); m_ac = m_ac + m_r; end
                4'h6: begin q.push_back(mk(4'd5, L_AC, 3'd2, 0, 0)); m_ac = m_ac - m_r; end
                4'h9: begin q.push_back(mk(4'd2, L_AC, 3'd3, 0, 0)); m_ac = m_ac + 16'd1; end
                4'h1, 4'h2, 4'h7, 4'h8: begin
                    a = iram[m_pc[7:0]];
                    q.push_back(mk(4'd3, L_AR, 3'd0, 0, 0));
                    if (op == 4'h1 || op == 4'h2) begin
                        q.push_back(mk(4'd6, L_AR | L_INC, 3'd0, 0, 0));
                        m_pc = m_pc + 16'd1;
                        stall = w;
                        tmo = 0;
`ifdef SEQ_WAIT_TIMEOUT_EN
                        if (w >= TMO) begin stall = TMO; tmo = 1; end
`endif
                        repeat (stall) q.push_back(mk(op == 4'h1 ? 4'd7 : 4'd2, 7'd0, 3'd0, 1, op == 4'h2));
                        if (tmo) begin
                            m_rest = REST_ERR;
                            done = 1;
                        end else if (op == 4'h1) begin
                            q.push_back(mk(4'd7, L_DR, 3'd0, 1, 0));
                            q.push_back(mk(4'd4, L_AC, 3'd0, 0, 0));
                            m_ac = m_dram[a[7:0]];
                        end else begin
                            q.push_back(mk(4'd2, 7'd0, 3'd0, 1, 1));
                            m_dram[a[7:0]] = m_ac;
                        end
                    end else if (op == 4'h7 || m_ac == 16'd0) begin
                        q.push_back(mk(4'd6, L_PC, 3'd0, 0, 0));
                        m_pc = a;
                    end else begin
                        q.push_back(mk(4'd6, L_INC, 3'd0, 0, 0));
                        m_pc = m_pc + 16'd1;
                    end
                end
                4'hF: begin m_rest = REST_HALT; done = 1; end
                default: begin m_rest = REST_ERR; done = 1; end
            endcase
        end
    endtask

    int busy_cnt = 0, req_cnt = 0, wesel_cnt = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            check("cycle", 32'(dut_vec), 32'(q.size() > 0 ? q.pop_front() : m_rest));
            if (busy) busy_cnt++;
            if (dram_req) req_cnt++;
            if (dram_we && bus_sel == 4'd2) wesel_cnt++;
        end
    end

    task automatic run(input int w);
        int k;
        wait_n = w;
        busy_cnt = 0; req_cnt = 0; wesel_cnt = 0;
        @(posedge clk); #2;
        build(w);
        start = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;   // start held while busy: must be ignored
        start = 1'b0;
        k = 0;
        while (k < 400 && !(q.size() == 0 && !busy)) begin
            @(negedge clk); #1;
            k++;
        end
        check("run_done", 32'(k < 400), 32'd1);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 256; i++) begin iram[i] = 16'h0; dram[i] = 16'h0; end
        iram[8'h00] = 16'h0000; iram[8'h01] = 16'hF000;
        iram[8'h02] = 16'h1000; iram[8'h03] = 16'h0010; iram[8'h04] = 16'hF000;
        iram[8'h05] = 16'h1000; iram[8'h06] = 16'h0011;
        iram[8'h07] = 16'h2000; iram[8'h08] = 16'h0020; iram[8'h09] = 16'hF000;
        iram[8'h0A] = 16'h8000; iram[8'h0B] = 16'h0030; iram[8'h0C] = 16'hF000;
        iram[8'h0D] = 16'h3000; iram[8'h0E] = 16'h6000;
        iram[8'h0F] = 16'h8000; iram[8'h10] = 16'h0030;
        iram[8'h30] = 16'h9000; iram[8'h31] = 16'h4000; iram[8'h32] = 16'h5000;
        iram[8'h33] = 16'hA000;
        iram[8'h34] = 16'h7000; iram[8'h35] = 16'h0040; iram[8'h40] = 16'hF000;
        iram[8'h41] = 16'h1000; iram[8'h42] = 16'h0010;
        iram[8'h43] = 16'h1000; iram[8'h44] = 16'h0010;
        dram[8'h10] = 16'h1234; dram[8'h11] = 16'h00FF;
        for (int i = 0; i < 256; i++) m_dram[i] = dram[i];

        repeat (3) @(posedge clk);
        #1 check("reset_outputs", 32'(dut_vec), 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run(0);     // NOP, HALT
        check("r1_pc", 32'(pc), 32'h2);
        check("r1_halted", 32'(halted), 32'd1);
        check("r1_busy_cycles", 32'(busy_cnt), 32'd6);

        run(2);     // LDAC 0x10 with 2 wait cycles, HALT
        check("r2_ac", 32'(ac), 32'h1234);
        check("r2_req_cycles", 32'(req_cnt), 32'd3);
        check("r2_busy_cycles", 32'(busy_cnt), 32'd12);  // LDAC 9 + HALT 3

        run(1);     // LDAC 0x11, STAC 0x20, HALT
        check("r3_dram20", 32'(dram[8'h20]), 32'h00FF);
        check("r3_we_sel_ac", 32'(wesel_cnt), 32'd2);

        run(0);     // JMPZ with AC=0xFF: not taken
        check("r4_pc", 32'(pc), 32'h000D);

        run(0);     // MVACR, SUB -> 0, JMPZ taken, INCAC, MVRAC, ADD, illegal
        check("r5_err", 32'(err), 32'd1);
        check("r5_pc", 32'(pc), 32'h0034);
        check("r5_ac", 32'(ac), 32'h01FE);

        run(0);     // resume after ERR: JMP 0x40, HALT
        check("r6_err", 32'(err), 32'd0);
        check("r6_pc", 32'(pc), 32'h0041);

`ifdef SEQ_WAIT_TIMEOUT_EN
        run(100);   // LDAC with ready stuck low
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_req_cycles", 32'(req_cnt), 32'(TMO));
`endif

        // Reset in the middle of a data-RAM read.
        wait_n = 50;
        @(posedge clk); #2;
        build(50);
        start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        k = 0;
        while (k < 20 && !dram_req) begin @(negedge clk); k++; end
        check("mid_req_seen", 32'(dram_req), 32'd1);
        @(posedge clk); #3 rst_n = 1'b0;
        #1 check("mid_reset_outputs", 32'(dut_vec), 32'd0);
        q.delete();
        m_rest = REST_IDLE; m_pc = 0; m_ac = 0; m_r = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        run(0);     // fetch restarts from PC 0
        check("post_reset_pc", 32'(pc), 32'h2);
        check("post_reset_halted", 32'(halted), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
